// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchronizer, per-button debounce
// counter, registered level plus one-cycle press/release pulses.
module button_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [N-1:0] btn_n,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [N-1:0] w_samp;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp = r_sync2;

    for (genvar g = 0; g < N; g++) begin : g_btn
        logic [CNT_W-1:0] r_cnt;
        logic             r_stable;
        logic             r_press;
        logic             r_rel;

        // Any sample agreeing with the stable level restarts the count,
        // so only an unbroken run of mismatches is accepted.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_cnt    <= '0;
                r_stable <= 1'b0;
                r_press  <= 1'b0;
                r_rel    <= 1'b0;
            end else if (w_samp[g] == r_stable) begin
                r_cnt   <= '0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else if (r_cnt == C_LAST) begin
                r_cnt    <= '0;
                r_stable <= w_samp[g];
                r_press  <= w_samp[g];
                r_rel    <= ~w_samp[g];
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end
        end

        assign level[g]         = r_stable;
        assign press[g]         = r_press;
        assign release_pulse[g] = r_rel;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed vector bench for button_conditioner with DEBOUNCE_CYCLES = 4.
module tb_button_conditioner;

    localparam int N = 4;
    localparam int D = 4;

    typedef struct {
        logic       rst;
        logic [3:0] btn_n;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] btn_n = 4'hF;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] release_pulse;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    button_conditioner #(
        .N(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .btn_n(btn_n),
        .level(level),
        .press(press),
        .release_pulse(release_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic add_n(input int cnt, input logic rst, input logic [3:0] b,
                         input logic [3:0] l, input logic [3:0] p,
                         input logic [3:0] r);
        vec_t v;
        v.rst = rst; v.btn_n = b; v.lvl = l; v.prs = p; v.rel = r;
        for (int i = 0; i < cnt; i++) vecs.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic [3:0] b);
        @(negedge Clk);
        Reset = rst;
        btn_n = b;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    int cnt;

    initial begin
        // reset
        add_n(3, 1, 4'hF, 4'h0, 4'h0, 4'h0);
        add_n(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        // clean press on bit 1, seen at vector 4
        add_n(5, 0, 4'hD, 4'h0, 4'h0, 4'h0);
        add_n(1, 0, 4'hD, 4'h2, 4'h2, 4'h0);
        add_n(1, 0, 4'hD, 4'h2, 4'h0, 4'h0);
        // release of bit 1
        add_n(5, 0, 4'hF, 4'h2, 4'h0, 4'h0);
        add_n(1, 0, 4'hF, 4'h0, 4'h0, 4'h2);
        add_n(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        // bounce on bit 2: low 3, high 1, low 2, high
        add_n(3, 0, 4'hB, 4'h0, 4'h0, 4'h0);
        add_n(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        add_n(2, 0, 4'hB, 4'h0, 4'h0, 4'h0);
        add_n(4, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        // then held low
        add_n(5, 0, 4'hB, 4'h0, 4'h0, 4'h0);
        add_n(1, 0, 4'hB, 4'h4, 4'h4, 4'h0);
        add_n(1, 0, 4'hB, 4'h4, 4'h0, 4'h0);
        add_n(5, 0, 4'hF, 4'h4, 4'h0, 4'h0);
        add_n(1, 0, 4'hF, 4'h0, 4'h0, 4'h4);
        add_n(1, 0, 4'hF, 4'h0, 4'h0, 4'h0);
        // simultaneous bits 0 and 3
        add_n(5, 0, 4'h6, 4'h0, 4'h0, 4'h0);
        add_n(1, 0, 4'h6, 4'h9, 4'h9, 4'h0);
        add_n(1, 0, 4'h6, 4'h9, 4'h0, 4'h0);
        // reset while held: no release pulse, everything cleared
        add_n(2, 1, 4'h6, 4'h0, 4'h0, 4'h0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].btn_n);
            chk("level", i, level, vecs[i].lvl);
            chk("press", i, press, vecs[i].prs);
            chk("release", i, release_pulse, vecs[i].rel);
        end

        // reset mid-count on bit 0
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 4'hE);
            chk("midcnt_press", i, press, 4'h0);
            chk("midcnt_level", i, level, 4'h0);
        end
        apply(1'b1, 4'hE);
        chk("rst_press", 0, press, 4'h0);
        chk("rst_level", 0, level, 4'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 4'hE);
            cnt++;
            if (press != 4'h0) break;
        end
        chk("post_rst_edges", 0, 4'(cnt), 4'(6));
        chk("post_rst_press", 0, press, 4'h1);
        chk("post_rst_level", 0, level, 4'h1);
        apply(1'b0, 4'hE);
        chk("post_rst_pulse_end", 0, press, 4'h0);
        chk("post_rst_rel", 0, release_pulse, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
